// File: rtl/bin2bcd_param.sv
//------------------------------------------------------------------------------
// Module   : bin2bcd_param
// Brief    : Iterative shift-add-3 binary to packed-BCD converter, one bit/cycle.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module bin2bcd_param #(
  parameter int IN_W   = 8,
  parameter int DIGITS = 3,
  parameter int SIGNED = 0
) (
  input  logic                  clk,
  input  logic                  nrst,
  input  logic [IN_W-1:0]       in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic [DIGITS-1:0]     nz_mask,
  output logic                  out_neg,
  output logic                  out_ovf,
  output logic                  out_valid,
  input  logic                  out_ready
);

  localparam int c_CNT_W = $clog2(IN_W + 1);
  localparam int c_BCD_W = 4 * DIGITS;
  localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(IN_W - 1);

  if (IN_W < 2 || IN_W > 32 || DIGITS < 1 || DIGITS > 10 ||
      (SIGNED != 0 && SIGNED != 1)) begin : g_param_err
    $error("bin2bcd_param: parameter out of range");
  end

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CONV = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [IN_W-1:0]      r_shift;
  logic [c_BCD_W-1:0]   r_bcd;
  logic [c_CNT_W-1:0]   r_cnt;
  logic [DIGITS-1:0]    r_nz;
  logic                 r_neg;
  logic                 r_ovf;

  logic                 w_sign;
  logic [IN_W:0]        w_mag_full;
  logic [IN_W-1:0]      w_mag;
  logic                 w_mag_zero;
  logic [c_BCD_W-1:0]   w_adj;
  logic [3:0]           w_dig;
  logic                 w_ovf_bit;
  logic [c_BCD_W-1:0]   w_bcd_sh;
  logic [IN_W-1:0]      w_shift_sh;
  logic [DIGITS-1:0]    w_nz_nxt;
  logic                 w_any;

  // Negation is one bit wider so the most negative input yields its true magnitude.
  if (SIGNED != 0) begin : g_signed
    logic [IN_W:0] w_ext;
    assign w_ext      = {in_data[IN_W-1], in_data};
    assign w_sign     = in_data[IN_W-1];
    assign w_mag_full = w_sign ? -w_ext : w_ext;
  end else begin : g_unsigned
    assign w_sign     = 1'b0;
    assign w_mag_full = {1'b0, in_data};
  end

  assign w_mag      = w_mag_full[IN_W-1:0];
  assign w_mag_zero = (w_mag_full == '0);

  always_comb begin
    w_adj = r_bcd;
    w_dig = 4'd0;
    for (int i = 0; i < DIGITS; i++) begin
      w_dig = r_bcd[4*i +: 4];
      if (w_dig >= 4'd5) begin
        w_adj[4*i +: 4] = w_dig + 4'd3;
      end
    end
  end

  // The bit leaving the top digit is the part of the value that does not fit.
  assign {w_ovf_bit, w_bcd_sh, w_shift_sh} = {w_adj, r_shift, 1'b0};

  always_comb begin
    w_nz_nxt = '0;
    w_any    = 1'b0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      w_any       = w_any | (w_bcd_sh[4*i +: 4] != 4'd0);
      w_nz_nxt[i] = w_any;
    end
    w_nz_nxt[0] = 1'b1;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (in_valid)        w_state_nxt = S_CONV;
      S_CONV:  if (r_cnt == c_LAST) w_state_nxt = S_DONE;
      S_DONE:  if (out_ready)       w_state_nxt = S_IDLE;
      default:                      w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_shift <= '0;
      r_bcd   <= '0;
      r_cnt   <= '0;
      r_nz    <= '0;
      r_neg   <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_shift <= w_mag;
            r_bcd   <= '0;
            r_cnt   <= '0;
            r_nz    <= '0;
            r_neg   <= w_sign & ~w_mag_zero;
            r_ovf   <= 1'b0;
          end
        end
        S_CONV: begin
          r_shift <= w_shift_sh;
          r_bcd   <= w_bcd_sh;
          r_ovf   <= r_ovf | w_ovf_bit;
          r_cnt   <= r_cnt + c_CNT_W'(1);
          if (r_cnt == c_LAST) begin
            r_nz <= w_nz_nxt;
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (r_state == S_IDLE);
  assign out_valid = (r_state == S_DONE);
  assign bcd_out   = r_bcd;
  assign nz_mask   = r_nz;
  assign out_neg   = r_neg;
  assign out_ovf   = r_ovf;

endmodule

`default_nettype wire
